// File: rtl/pipeline_sink_bridge.sv
// Terminating receiver for the stall/clock-enable pipeline protocol.
// Absorbs the last stage's data/valid stream into a small FWFT FIFO and
// re-presents it on a valid/ready interface. Flush empties it in step with
// the rest of the pipeline.
module pipeline_sink_bridge #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_stall,
  output logic              o_current_ce,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic                         push, pop;

  // Stall and valid come from registered count only, so upstream sees no
  // combinational path from its own valid or from the consumer's ready.
  assign o_stall      = (count == FULL);
  assign o_valid      = (count != '0);
  assign push         = i_valid & ~o_stall & ~i_flush;
  assign pop          = o_valid & i_ready & ~i_flush;
  assign o_current_ce = push;
  assign o_data       = mem[rd_ptr];
  assign o_count      = count;

  // Pointer and occupancy update; flush wins over any concurrent handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; not reset and not cleared by flush (data is qualified
  // by count, so stale entries are never visible).
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // Occupancy can never exceed capacity; guards against pointer/count bugs.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) count <= FULL);

endmodule
